ddr_word_bridge: RTL and testbench

- Sits directly downstream of the data cache, between the cache's DDR-side byte port and the DDR controller's 32-bit local port.
- Converts single-byte cache reads and writes into word commands with byte enables.
- Keeps a one-entry read word buffer, so cache line fills (4 consecutive bytes) cost one DDR read.
- Completes each request with a one-cycle ready pulse back to the cache.

---
 rtl/ddr_word_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_ddr_word_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_word_bridge.sv
// Byte-wide cache port to 32-bit DDR local port bridge.
// Holds one read word so that a 4-byte line fill costs a single DDR read.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a cache request; address/data latched here
// RD_CMD  | DDR read command presented until the controller accepts it
// RD_WAIT | read accepted, waiting for the DDR read data
// WR_CMD  | DDR write command presented until the controller accepts it
// RESP    | one-cycle ready pulse back to the cache
// RELEASE | waiting for the cache to drop both request enables
module ddr_word_bridge #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_LENGTH = 19,
    parameter int DDR_DATA_WIDTH = 32,
    parameter int BYTE_SEL_BITS  = 2
) (
    input  logic                                    Clk,
    input  logic                                    ResetFlag,
    input  logic                                    CacheWriteEnIn,
    input  logic                                    CacheReadEnIn,
    input  logic [ADDRESS_LENGTH-1:0]               CacheAddressIn,
    input  logic [DATA_WIDTH-1:0]                   CacheDataIn,
    output logic                                    CacheWriteReadyOut,
    output logic                                    CacheReadReadyOut,
    output logic [DATA_WIDTH-1:0]                   CacheDataOut,
    input  logic                                    DdrCmdReadyIn,
    input  logic                                    DdrReadDataValidIn,
    input  logic [DDR_DATA_WIDTH-1:0]               DdrReadDataIn,
    output logic                                    DdrReadReqOut,
    output logic                                    DdrWriteReqOut,
    output logic [ADDRESS_LENGTH-BYTE_SEL_BITS-1:0] DdrAddressOut,
    output logic [DDR_DATA_WIDTH-1:0]               DdrWriteDataOut,
    output logic [3:0]                              DdrByteEnOut
);

    localparam int LANES       = DDR_DATA_WIDTH / DATA_WIDTH;
    localparam int WORD_ADDR_W = ADDRESS_LENGTH - BYTE_SEL_BITS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_WAIT = 3'd2,
        WR_CMD  = 3'd3,
        RESP    = 3'd4,
        RELEASE = 3'd5
    } stateType;

    stateType state;
    stateType nextState;

    logic [ADDRESS_LENGTH-1:0] addrReg;
    logic [DATA_WIDTH-1:0]     dataReg;
    logic                      isWrite;
    logic [DATA_WIDTH-1:0]     dataOutReg;

    logic                      bufValid;
    logic [WORD_ADDR_W-1:0]    bufWordAddr;
    logic [DDR_DATA_WIDTH-1:0] bufWord;

    logic [WORD_ADDR_W-1:0]    inWordAddr;
    logic [WORD_ADDR_W-1:0]    regWordAddr;
    logic [BYTE_SEL_BITS-1:0]  inLane;
    logic [BYTE_SEL_BITS-1:0]  regLane;
    logic                      bufHit;
    logic                      bufMatchReg;
    logic [DATA_WIDTH-1:0]     hitByte;
    logic [DATA_WIDTH-1:0]     missByte;
    logic [DDR_DATA_WIDTH-1:0] mergedWord;

    assign inWordAddr  = CacheAddressIn[ADDRESS_LENGTH-1:BYTE_SEL_BITS];
    assign inLane      = CacheAddressIn[BYTE_SEL_BITS-1:0];
    assign regWordAddr = addrReg[ADDRESS_LENGTH-1:BYTE_SEL_BITS];
    assign regLane     = addrReg[BYTE_SEL_BITS-1:0];
    assign bufHit      = bufValid && (bufWordAddr == inWordAddr);
    assign bufMatchReg = bufValid && (bufWordAddr == regWordAddr);
    assign CacheDataOut = dataOutReg;

    // Lane selection for hits, fresh DDR words, and write-through merging.
    always_comb begin
        hitByte    = '0;
        missByte   = '0;
        mergedWord = bufWord;
        for (int i = 0; i < LANES; i++) begin
            if (inLane == BYTE_SEL_BITS'(i)) begin
                hitByte = bufWord[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (regLane == BYTE_SEL_BITS'(i)) begin
                missByte = DdrReadDataIn[i*DATA_WIDTH +: DATA_WIDTH];
                mergedWord[i*DATA_WIDTH +: DATA_WIDTH] = dataReg;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetFlag) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState          = state;
        CacheWriteReadyOut = 1'b0;
        CacheReadReadyOut  = 1'b0;
        DdrReadReqOut      = 1'b0;
        DdrWriteReqOut     = 1'b0;
        DdrAddressOut      = '0;
        DdrWriteDataOut    = '0;
        DdrByteEnOut       = '0;
        case (state)
            IDLE: begin
                if (CacheWriteEnIn) begin
                    nextState = WR_CMD;
                end else if (CacheReadEnIn) begin
                    nextState = bufHit ? RESP : RD_CMD;
                end
            end
            RD_CMD: begin
                DdrReadReqOut = 1'b1;
                DdrAddressOut = regWordAddr;
                if (DdrCmdReadyIn) begin
                    nextState = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (DdrReadDataValidIn) begin
                    nextState = RESP;
                end
            end
            WR_CMD: begin
                DdrWriteReqOut  = 1'b1;
                DdrAddressOut   = regWordAddr;
                DdrWriteDataOut = {LANES{dataReg}};
                for (int i = 0; i < 4; i++) begin
                    DdrByteEnOut[i] = (regLane == BYTE_SEL_BITS'(i));
                end
                if (DdrCmdReadyIn) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                CacheWriteReadyOut = isWrite;
                CacheReadReadyOut  = !isWrite;
                nextState          = RELEASE;
            end
            RELEASE: begin
                if (!CacheReadEnIn && !CacheWriteEnIn) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!ResetFlag) begin
            addrReg     <= '0;
            dataReg     <= '0;
            isWrite     <= 1'b0;
            dataOutReg  <= '0;
            bufValid    <= 1'b0;
            bufWordAddr <= '0;
            bufWord     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CacheWriteEnIn) begin
                        addrReg <= CacheAddressIn;
                        dataReg <= CacheDataIn;
                        isWrite <= 1'b1;
                    end else if (CacheReadEnIn) begin
                        addrReg <= CacheAddressIn;
                        isWrite <= 1'b0;
                        if (bufHit) begin
                            dataOutReg <= hitByte;
                        end
                    end
                end
                RD_WAIT: begin
                    if (DdrReadDataValidIn) begin
                        bufValid    <= 1'b1;
                        bufWordAddr <= regWordAddr;
                        bufWord     <= DdrReadDataIn;
                        dataOutReg  <= missByte;
                    end
                end
                WR_CMD: begin
                    // Keep the read buffer coherent with the word just written.
                    if (DdrCmdReadyIn && bufMatchReg) begin
                        bufWord <= mergedWord;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_word_bridge.sv
// Directed bench for ddr_word_bridge: miss, line fill, write-through,
// simultaneous requests with release, and reset during a read.
module tb_ddr_word_bridge;

    logic        Clk = 1'b0;
    logic        ResetFlag;
    logic        CacheWriteEnIn;
    logic        CacheReadEnIn;
    logic [18:0] CacheAddressIn;
    logic [7:0]  CacheDataIn;
    logic        CacheWriteReadyOut;
    logic        CacheReadReadyOut;
    logic [7:0]  CacheDataOut;
    logic        DdrCmdReadyIn;
    logic        DdrReadDataValidIn;
    logic [31:0] DdrReadDataIn;
    logic        DdrReadReqOut;
    logic        DdrWriteReqOut;
    logic [16:0] DdrAddressOut;
    logic [31:0] DdrWriteDataOut;
    logic [3:0]  DdrByteEnOut;

    int total = 0;
    int bad = 0;
    int rdCmdCount = 0;
    int wrCmdCount = 0;
    int wrReqCycles = 0;
    int bothHigh = 0;

    ddr_word_bridge dut (
        .Clk                (Clk),
        .ResetFlag          (ResetFlag),
        .CacheWriteEnIn     (CacheWriteEnIn),
        .CacheReadEnIn      (CacheReadEnIn),
        .CacheAddressIn     (CacheAddressIn),
        .CacheDataIn        (CacheDataIn),
        .CacheWriteReadyOut (CacheWriteReadyOut),
        .CacheReadReadyOut  (CacheReadReadyOut),
        .CacheDataOut       (CacheDataOut),
        .DdrCmdReadyIn      (DdrCmdReadyIn),
        .DdrReadDataValidIn (DdrReadDataValidIn),
        .DdrReadDataIn      (DdrReadDataIn),
        .DdrReadReqOut      (DdrReadReqOut),
        .DdrWriteReqOut     (DdrWriteReqOut),
        .DdrAddressOut      (DdrAddressOut),
        .DdrWriteDataOut    (DdrWriteDataOut),
        .DdrByteEnOut       (DdrByteEnOut)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (DdrReadReqOut && DdrCmdReadyIn) rdCmdCount++;
        if (DdrWriteReqOut && DdrCmdReadyIn) wrCmdCount++;
        if (DdrWriteReqOut) wrReqCycles++;
        if (DdrReadReqOut && DdrWriteReqOut) bothHigh++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        ResetFlag = 1'b0;
        CacheWriteEnIn = 1'b0;
        CacheReadEnIn = 1'b0;
        CacheAddressIn = '0;
        CacheDataIn = '0;
        DdrCmdReadyIn = 1'b0;
        DdrReadDataValidIn = 1'b0;
        DdrReadDataIn = '0;
        tick();
        tick();
        total++;
        if ({CacheWriteReadyOut, CacheReadReadyOut, DdrReadReqOut, DdrWriteReqOut} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000",
                     {CacheWriteReadyOut, CacheReadReadyOut, DdrReadReqOut, DdrWriteReqOut});
        end
        total++;
        if (CacheDataOut !== 8'h00) begin
            bad++;
            $display("FAIL reset_data got=%h want=00", CacheDataOut);
        end
        total++;
        if ({DdrAddressOut, DdrWriteDataOut, DdrByteEnOut} !== 53'd0) begin
            bad++;
            $display("FAIL reset_ddr got=%h/%h/%b want=0", DdrAddressOut, DdrWriteDataOut, DdrByteEnOut);
        end
        ResetFlag = 1'b1;
        tick();
    endtask

    task automatic test_read_miss();
        int rd0;
        rd0 = rdCmdCount;
        CacheReadEnIn = 1'b1;
        CacheAddressIn = 19'h00104;
        DdrCmdReadyIn = 1'b1;
        tick();
        total++;
        if (DdrReadReqOut !== 1'b1 || DdrWriteReqOut !== 1'b0) begin
            bad++;
            $display("FAIL miss_rdreq got=%b%b want=10", DdrReadReqOut, DdrWriteReqOut);
        end
        total++;
        if (DdrAddressOut !== 17'h00041) begin
            bad++;
            $display("FAIL miss_addr got=%h want=00041", DdrAddressOut);
        end
        tick();
        DdrCmdReadyIn = 1'b0;
        total++;
        if (DdrReadReqOut !== 1'b0 || CacheReadReadyOut !== 1'b0) begin
            bad++;
            $display("FAIL miss_wait got=%b%b want=00", DdrReadReqOut, CacheReadReadyOut);
        end
        tick();
        DdrReadDataValidIn = 1'b1;
        DdrReadDataIn = 32'hDDCCBBAA;
        tick();
        DdrReadDataValidIn = 1'b0;
        DdrReadDataIn = '0;
        total++;
        if (CacheReadReadyOut !== 1'b1 || CacheDataOut !== 8'hAA) begin
            bad++;
            $display("FAIL miss_resp got=%b/%h want=1/aa", CacheReadReadyOut, CacheDataOut);
        end
        CacheReadEnIn = 1'b0;
        tick();
        total++;
        if (CacheReadReadyOut !== 1'b0 || CacheDataOut !== 8'hAA) begin
            bad++;
            $display("FAIL miss_pulse_hold got=%b/%h want=0/aa", CacheReadReadyOut, CacheDataOut);
        end
        tick();
        total++;
        if (rdCmdCount - rd0 !== 1) begin
            bad++;
            $display("FAIL miss_cmds got=%0d want=1", rdCmdCount - rd0);
        end
    endtask

    task automatic test_line_fill();
        int rd0;
        int wr0;
        logic [7:0] exp;
        rd0 = rdCmdCount;
        wr0 = wrCmdCount;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: exp = 8'hBB;
                1: exp = 8'hCC;
                default: exp = 8'hDD;
            endcase
            CacheReadEnIn = 1'b1;
            CacheAddressIn = 19'h00105 + 19'(i);
            tick();
            total++;
            if (CacheReadReadyOut !== 1'b1 || CacheDataOut !== exp || DdrReadReqOut !== 1'b0) begin
                bad++;
                $display("FAIL fill_%0d got=%b/%h rdreq=%b want=1/%h rdreq=0",
                         i, CacheReadReadyOut, CacheDataOut, DdrReadReqOut, exp);
            end
            CacheReadEnIn = 1'b0;
            tick();
            tick();
        end
        total++;
        if (rdCmdCount - rd0 !== 0 || wrCmdCount - wr0 !== 0) begin
            bad++;
            $display("FAIL fill_cmds got=%0d/%0d want=0/0", rdCmdCount - rd0, wrCmdCount - wr0);
        end
    endtask

    task automatic test_write();
        int rd0;
        int wc0;
        rd0 = rdCmdCount;
        wc0 = wrReqCycles;
        CacheWriteEnIn = 1'b1;
        CacheAddressIn = 19'h00106;
        CacheDataIn = 8'h5E;
        DdrCmdReadyIn = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (DdrWriteReqOut !== 1'b1 || DdrReadReqOut !== 1'b0 || DdrByteEnOut !== 4'b0100 ||
                DdrWriteDataOut !== 32'h5E5E5E5E || DdrAddressOut !== 17'h00041 ||
                CacheWriteReadyOut !== 1'b0) begin
                bad++;
                $display("FAIL wr_cmd_%0d got=%b%b be=%b d=%h a=%h rdy=%b want=10 be=0100 d=5e5e5e5e a=00041 rdy=0",
                         i, DdrWriteReqOut, DdrReadReqOut, DdrByteEnOut, DdrWriteDataOut,
                         DdrAddressOut, CacheWriteReadyOut);
            end
            if (i == 3) DdrCmdReadyIn = 1'b1;
            tick();
        end
        DdrCmdReadyIn = 1'b0;
        total++;
        if (CacheWriteReadyOut !== 1'b1 || CacheReadReadyOut !== 1'b0 || DdrWriteReqOut !== 1'b0) begin
            bad++;
            $display("FAIL wr_resp got=%b%b req=%b want=10 req=0",
                     CacheWriteReadyOut, CacheReadReadyOut, DdrWriteReqOut);
        end
        total++;
        if (wrReqCycles - wc0 !== 4) begin
            bad++;
            $display("FAIL wr_req_cycles got=%0d want=4", wrReqCycles - wc0);
        end
        CacheWriteEnIn = 1'b0;
        tick();
        total++;
        if (CacheWriteReadyOut !== 1'b0) begin
            bad++;
            $display("FAIL wr_pulse got=%b want=0", CacheWriteReadyOut);
        end
        tick();
        CacheReadEnIn = 1'b1;
        CacheAddressIn = 19'h00106;
        tick();
        total++;
        if (CacheReadReadyOut !== 1'b1 || CacheDataOut !== 8'h5E) begin
            bad++;
            $display("FAIL wr_readback got=%b/%h want=1/5e", CacheReadReadyOut, CacheDataOut);
        end
        CacheReadEnIn = 1'b0;
        tick();
        tick();
        total++;
        if (rdCmdCount - rd0 !== 0) begin
            bad++;
            $display("FAIL wr_readback_cmds got=%0d want=0", rdCmdCount - rd0);
        end
    endtask

    task automatic test_simultaneous();
        int rd0;
        int wr0;
        rd0 = rdCmdCount;
        wr0 = wrCmdCount;
        CacheReadEnIn = 1'b1;
        CacheWriteEnIn = 1'b1;
        CacheAddressIn = 19'h00200;
        CacheDataIn = 8'h77;
        DdrCmdReadyIn = 1'b1;
        tick();
        total++;
        if (DdrWriteReqOut !== 1'b1 || DdrReadReqOut !== 1'b0 || DdrAddressOut !== 17'h00080) begin
            bad++;
            $display("FAIL sim_first got=%b%b a=%h want=10 a=00080",
                     DdrWriteReqOut, DdrReadReqOut, DdrAddressOut);
        end
        tick();
        total++;
        if (CacheWriteReadyOut !== 1'b1 || CacheReadReadyOut !== 1'b0) begin
            bad++;
            $display("FAIL sim_resp got=%b%b want=10", CacheWriteReadyOut, CacheReadReadyOut);
        end
        CacheWriteEnIn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (DdrReadReqOut !== 1'b0 || DdrWriteReqOut !== 1'b0 ||
                CacheReadReadyOut !== 1'b0 || CacheWriteReadyOut !== 1'b0) begin
                bad++;
                $display("FAIL sim_hold_%0d got=%b%b%b%b want=0000", i,
                         DdrReadReqOut, DdrWriteReqOut, CacheReadReadyOut, CacheWriteReadyOut);
            end
        end
        CacheReadEnIn = 1'b0;
        DdrCmdReadyIn = 1'b0;
        tick();
        total++;
        if (rdCmdCount - rd0 !== 0 || wrCmdCount - wr0 !== 1) begin
            bad++;
            $display("FAIL sim_cmds got=%0d/%0d want=0/1", rdCmdCount - rd0, wrCmdCount - wr0);
        end
        CacheReadEnIn = 1'b1;
        CacheAddressIn = 19'h00107;
        tick();
        total++;
        if (CacheReadReadyOut !== 1'b1 || CacheDataOut !== 8'hDD || DdrReadReqOut !== 1'b0) begin
            bad++;
            $display("FAIL sim_buffer_kept got=%b/%h rdreq=%b want=1/dd rdreq=0",
                     CacheReadReadyOut, CacheDataOut, DdrReadReqOut);
        end
        CacheReadEnIn = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_read();
        CacheReadEnIn = 1'b1;
        CacheAddressIn = 19'h00300;
        DdrCmdReadyIn = 1'b1;
        tick();
        tick();
        DdrCmdReadyIn = 1'b0;
        ResetFlag = 1'b0;
        tick();
        total++;
        if ({CacheWriteReadyOut, CacheReadReadyOut, DdrReadReqOut, DdrWriteReqOut} !== 4'b0000 ||
            CacheDataOut !== 8'h00 || {DdrAddressOut, DdrWriteDataOut, DdrByteEnOut} !== 53'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%b%b%b%b d=%h a=%h want=0000 d=00 a=0",
                     CacheWriteReadyOut, CacheReadReadyOut, DdrReadReqOut, DdrWriteReqOut,
                     CacheDataOut, DdrAddressOut);
        end
        ResetFlag = 1'b1;
        CacheReadEnIn = 1'b0;
        tick();
        DdrReadDataValidIn = 1'b1;
        DdrReadDataIn = 32'h11223344;
        tick();
        DdrReadDataValidIn = 1'b0;
        total++;
        if (CacheReadReadyOut !== 1'b0 || CacheDataOut !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_stale got=%b/%h want=0/00", CacheReadReadyOut, CacheDataOut);
        end
        tick();
        CacheReadEnIn = 1'b1;
        CacheAddressIn = 19'h00300;
        tick();
        total++;
        if (DdrReadReqOut !== 1'b1 || CacheReadReadyOut !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_remiss got=%b%b want=10", DdrReadReqOut, CacheReadReadyOut);
        end
        DdrCmdReadyIn = 1'b1;
        tick();
        DdrCmdReadyIn = 1'b0;
        DdrReadDataValidIn = 1'b1;
        tick();
        DdrReadDataValidIn = 1'b0;
        DdrReadDataIn = '0;
        total++;
        if (CacheReadReadyOut !== 1'b1 || CacheDataOut !== 8'h44) begin
            bad++;
            $display("FAIL rst_mid_refill got=%b/%h want=1/44", CacheReadReadyOut, CacheDataOut);
        end
        CacheReadEnIn = 1'b0;
        tick();
        tick();
        total++;
        if (bothHigh !== 0) begin
            bad++;
            $display("FAIL both_req got=%0d want=0", bothHigh);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_line_fill();
        test_write();
        test_simultaneous();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
